// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver
// Time-multiplexes four 7-segment codes from the stopwatch onto one shared
// segment bus and four digit enables for a common-anode 4-digit display.
// The codes are snapshotted once per frame so a digit never tears mid-scan,
// and every digit slot opens with a blanked dead-time to suppress ghosting.
//
// Output timing: seg/dp/an/frame_start are all registered and reflect the
// (d, div_cnt) state one clock earlier. frame_start is a single-cycle pulse
// with no handshake: it is high for exactly the cycle after a snapshot edge.
module seven_seg_scan_driver #(
    parameter int REFRESH_DIV     = 1000,
    parameter int DEAD_CYCLES     = 16,
    parameter int SEG_ACTIVE_LOW  = 1,
    parameter int AN_ACTIVE_LOW   = 1,
    parameter int DP_DIGIT        = 1,
    parameter int BLANK_LEAD_ZERO = 1
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [6:0] dig0_code,
    input  logic [6:0] dig1_code,
    input  logic [6:0] dig2_code,
    input  logic [6:0] dig3_code,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       frame_start
);

    // Slot counter width; REFRESH_DIV >= 2 always gives at least one bit.
    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] DEAD_END  = CW'(DEAD_CYCLES);
    localparam logic [6:0]    ZERO_CODE = 7'b1111110;

    // Pin-level inversion masks and the matching "everything off" levels.
    localparam logic [6:0] SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic       DP_INV  = (SEG_ACTIVE_LOW != 0);
    localparam logic [3:0] AN_INV  = (AN_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

    // Parameter sanity, caught at elaboration.
    if (REFRESH_DIV < 2) begin : g_chk_div_min
        $error("seven_seg_scan_driver: REFRESH_DIV must be >= 2");
    end
    if (REFRESH_DIV < DEAD_CYCLES + 1) begin : g_chk_div_dead
        $error("seven_seg_scan_driver: REFRESH_DIV must be >= DEAD_CYCLES+1");
    end
    if (DEAD_CYCLES < 0) begin : g_chk_dead
        $error("seven_seg_scan_driver: DEAD_CYCLES must be >= 0");
    end
    if ((DP_DIGIT < 0) || (DP_DIGIT > 4)) begin : g_chk_dp
        $error("seven_seg_scan_driver: DP_DIGIT must be in 0..4");
    end

    // Scan state.
    logic [CW-1:0] div_cnt;
    logic [1:0]    d;
    logic          load_pending;

    // Frame snapshot of the four incoming codes.
    logic [6:0] snap0;
    logic [6:0] snap1;
    logic [6:0] snap2;
    logic [6:0] snap3;

    // Combinational decode of the current state (active-high, pre-polarity).
    logic       slot_wrap;
    logic       take_snap;
    logic [6:0] view0;
    logic [6:0] view1;
    logic [6:0] view2;
    logic [6:0] view3;
    logic [6:0] sel_code;
    logic       in_dead;
    logic       lead_blank;
    logic       digit_on;
    logic       dp_match;
    logic [6:0] seg_on;
    logic       dp_on;
    logic [3:0] an_on;

    assign slot_wrap = (div_cnt == CNT_LAST);
    assign take_snap = load_pending | (slot_wrap & (d == 2'd3));

    // Slot counter and digit index: div_cnt wraps every REFRESH_DIV cycles and d steps 0..3.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            div_cnt <= '0;
            d       <= 2'd0;
        end else if (slot_wrap) begin
            div_cnt <= '0;
            d       <= d + 2'd1;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

    // Snapshot the codes at the end of each frame, and once right after reset release.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            snap0        <= 7'd0;
            snap1        <= 7'd0;
            snap2        <= 7'd0;
            snap3        <= 7'd0;
            load_pending <= 1'b1;
            frame_start  <= 1'b0;
        end else begin
            frame_start <= take_snap;
            if (take_snap) begin
                snap0        <= dig0_code;
                snap1        <= dig1_code;
                snap2        <= dig2_code;
                snap3        <= dig3_code;
                load_pending <= 1'b0;
            end
        end
    end

    // Select and gate the digit shown in the current slot (active-high levels).
    always_comb begin
        // On the load edge after reset the snapshot registers still hold the
        // reset value; look through to the inputs so a zero dead-time slot 0
        // shows the freshly loaded code rather than a cleared one.
        view0 = load_pending ? dig0_code : snap0;
        view1 = load_pending ? dig1_code : snap1;
        view2 = load_pending ? dig2_code : snap2;
        view3 = load_pending ? dig3_code : snap3;

        sel_code = 7'd0;
        case (d)
            2'd0:    sel_code = view0;
            2'd1:    sel_code = view1;
            2'd2:    sel_code = view2;
            default: sel_code = view3;
        endcase

        in_dead    = (div_cnt < DEAD_END);
        lead_blank = (BLANK_LEAD_ZERO != 0) && (d == 2'd3) && (view3 == ZERO_CODE);
        digit_on   = !in_dead && !lead_blank;
        dp_match   = ({30'd0, d} == DP_DIGIT);

        seg_on = 7'd0;
        dp_on  = 1'b0;
        an_on  = 4'd0;
        if (digit_on) begin
            seg_on = sel_code;
            dp_on  = dp_match;
            an_on  = 4'b0001 << d;
        end
    end

    // Output register: pin polarity is applied here so the pins never glitch.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            seg <= SEG_INV;
            dp  <= DP_INV;
            an  <= AN_INV;
        end else begin
            seg <= seg_on ^ SEG_INV;
            dp  <= dp_on ^ DP_INV;
            an  <= an_on ^ AN_INV;
        end
    end

endmodule
